// File: rtl/if_id_fetch_queue.sv
// Decoupling instruction queue between IF and ID: holds up to DEPTH fetch bundles in order
// and presents the oldest to ID. A WB flush or ID branch redirect empties it.
module if_id_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int BUS_W = 112
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             if_to_fq_valid,
  input  logic [BUS_W-1:0] if_to_fq_bus,
  output logic             fq_allowin,
  output logic             fq_to_id_valid,
  output logic [BUS_W-1:0] fq_to_id_bus,
  input  logic             id_allowin,
  input  logic             flush,
  input  logic             br_taken,
  output logic [PTR_W:0]   fq_count,
  output logic             fq_excep_hold
);

  // Handshake: a transfer happens on a cycle where valid and the receiver's
  // allowin are both high; neither side's allowin depends on its own valid.

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [BUS_W-1:0] entry [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             excep_hold;
  logic             kill;
  logic             enq;
  logic             deq;

  assign kill           = flush | br_taken;
  // Full is judged by occupancy alone so a same-cycle dequeue never opens a slot.
  assign fq_allowin     = resetn & ~kill & ~excep_hold & (count != CNT_FULL);
  assign enq            = if_to_fq_valid & fq_allowin;
  assign fq_to_id_valid = (count != '0) & entry_vld[rd_ptr] & ~kill;
  assign deq            = fq_to_id_valid & id_allowin;
  assign fq_to_id_bus   = entry[rd_ptr];
  assign fq_count       = count;
  assign fq_excep_hold  = excep_hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      excep_hold <= 1'b0;
      entry_vld  <= '0;
    end else if (kill) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      excep_hold <= 1'b0;
      entry_vld  <= '0;
    end else begin
      if (enq) begin
        wr_ptr            <= wr_ptr + PTR_ONE;
        entry_vld[wr_ptr] <= 1'b1;
        // An exception bundle is the last one admitted until the pipe is killed.
        if (if_to_fq_bus[47]) excep_hold <= 1'b1;
      end
      if (deq) begin
        rd_ptr            <= rd_ptr + PTR_ONE;
        entry_vld[rd_ptr] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (enq) begin
      entry[wr_ptr] <= if_to_fq_bus;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed scenarios plus random traffic,
// all compared against an in-order queue model of the fetch queue.
module tb_if_id_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int BUS_W = 112;

  logic             clk = 1'b0;
  logic             resetn;
  logic             if_to_fq_valid;
  logic [BUS_W-1:0] if_to_fq_bus;
  logic             fq_allowin;
  logic             fq_to_id_valid;
  logic [BUS_W-1:0] fq_to_id_bus;
  logic             id_allowin;
  logic             flush;
  logic             br_taken;
  logic [PTR_W:0]   fq_count;
  logic             fq_excep_hold;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the queue, oldest first, plus the exception hold flag.
  logic [BUS_W-1:0] exp_q[$];
  logic             m_hold;
  logic             e_allowin;
  logic             e_valid;
  logic [BUS_W-1:0] e_head;
  int               e_count;
  logic             e_hold;

  if_id_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .BUS_W(BUS_W)) dut (
    .clk(clk), .resetn(resetn),
    .if_to_fq_valid(if_to_fq_valid), .if_to_fq_bus(if_to_fq_bus),
    .fq_allowin(fq_allowin), .fq_to_id_valid(fq_to_id_valid), .fq_to_id_bus(fq_to_id_bus),
    .id_allowin(id_allowin), .flush(flush), .br_taken(br_taken),
    .fq_count(fq_count), .fq_excep_hold(fq_excep_hold)
  );

  always #5 clk = ~clk;

  function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc, input logic ex, input logic [5:0] ecode);
    logic [31:0] inst;
    logic [8:0]  esub;
    inst = $urandom;
    esub = 9'($urandom_range(0, 511));
    return {inst, pc, ex, ecode, esub, pc ^ 32'hdead_0000};
  endfunction

  // Drive one cycle's inputs (called just after a falling edge) and form the model's expectations.
  task automatic set_in(input logic v, input logic [BUS_W-1:0] b, input logic ida, input logic fl, input logic br);
    logic kill;
    if_to_fq_valid = v;
    if_to_fq_bus   = b;
    id_allowin     = ida;
    flush          = fl;
    br_taken       = br;
    kill      = fl | br;
    e_count   = exp_q.size();
    e_hold    = m_hold;
    e_allowin = resetn & ~kill & ~m_hold & (e_count < DEPTH);
    e_valid   = (e_count != 0) & ~kill;
    e_head    = (e_count != 0) ? exp_q[0] : '0;
  endtask

  // Apply the queue rules to the model, then advance to the next falling edge.
  task automatic tick();
    if (flush | br_taken) begin
      exp_q.delete();
      m_hold = 1'b0;
    end else begin
      if (e_valid & id_allowin) void'(exp_q.pop_front());
      if (if_to_fq_valid & e_allowin) begin
        exp_q.push_back(if_to_fq_bus);
        if (if_to_fq_bus[47]) m_hold = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    exp_q.delete();
    m_hold = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++; if (fq_to_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", fq_to_id_valid); end
    checks++; if (fq_allowin !== 1'b0) begin errors++; $display("FAIL reset_allowin got %0b exp 0", fq_allowin); end
    checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fq_count); end
    checks++; if (fq_excep_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %0b exp 0", fq_excep_hold); end
    checks++; if (fq_to_id_bus !== '0) begin errors++; $display("FAIL reset_bus got %h exp 0", fq_to_id_bus); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 9; k++) begin
      set_in(k < 8, mk(32'h1c00_0000 + 32'(4 * k), 1'b0, 6'd0), 1'b1, 1'b0, 1'b0);
      #1;
      if (k < 8) begin
        checks++; if (fq_allowin !== 1'b1) begin errors++; $display("FAIL stream_allowin k=%0d got %0b exp 1", k, fq_allowin); end
      end
      checks++; if (fq_count !== 3'((k == 0) ? 0 : 1)) begin errors++; $display("FAIL stream_count k=%0d got %0d exp %0d", k, fq_count, (k == 0) ? 0 : 1); end
      checks++; if (fq_to_id_valid !== (k != 0)) begin errors++; $display("FAIL stream_valid k=%0d got %0b exp %0b", k, fq_to_id_valid, k != 0); end
      if (k != 0) begin
        checks++; if (fq_to_id_bus[79:48] !== 32'h1c00_0000 + 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_pc k=%0d got %h exp %h", k, fq_to_id_bus[79:48], 32'h1c00_0000 + 32'(4 * (k - 1))); end
        checks++; if (fq_to_id_bus !== e_head) begin errors++; $display("FAIL stream_bus k=%0d got %h exp %h", k, fq_to_id_bus, e_head); end
      end
      tick();
    end
  endtask

  task automatic test_fill_full();
    logic [31:0] pcs [5];
    int sent = 0;
    int got  = 0;
    pcs = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h10};
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      set_in(sent < 5, mk(pcs[(sent < 5) ? sent : 4], 1'b0, 6'd0), cyc >= 5, 1'b0, 1'b0);
      #1;
      if (cyc == 4) begin
        checks++; if (fq_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", fq_count); end
        checks++; if (fq_allowin !== 1'b0) begin errors++; $display("FAIL full_allowin got %0b exp 0", fq_allowin); end
      end
      if (cyc == 5) begin
        checks++; if (fq_allowin !== 1'b0) begin errors++; $display("FAIL full_deq_allowin got %0b exp 0", fq_allowin); end
      end
      checks++; if (fq_count !== 3'(e_count)) begin errors++; $display("FAIL fill_count cyc=%0d got %0d exp %0d", cyc, fq_count, e_count); end
      if (fq_to_id_valid && id_allowin) begin
        checks++; if (fq_to_id_bus[79:48] !== pcs[got]) begin errors++; $display("FAIL fill_order got %h exp %h", fq_to_id_bus[79:48], pcs[got]); end
        got++;
      end
      if (if_to_fq_valid && e_allowin) sent++;
      tick();
    end
    checks++; if (got != 5) begin errors++; $display("FAIL fill_delivered got %0d exp 5", got); end
  endtask

  task automatic test_simul();
    set_in(1'b1, mk(32'h20, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h24, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h28, 1'b0, 6'd0), 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fq_count !== 3'd2) begin errors++; $display("FAIL simul2_count_pre got %0d exp 2", fq_count); end
    checks++; if (fq_to_id_bus[79:48] !== 32'h20) begin errors++; $display("FAIL simul2_head_pre got %h exp 20", fq_to_id_bus[79:48]); end
    tick();
    set_in(1'b1, mk(32'h2c, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fq_count !== 3'd2) begin errors++; $display("FAIL simul2_count_post got %0d exp 2", fq_count); end
    checks++; if (fq_to_id_bus[79:48] !== 32'h24) begin errors++; $display("FAIL simul2_head_post got %h exp 24", fq_to_id_bus[79:48]); end
    tick();
    set_in(1'b1, mk(32'h30, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h34, 1'b0, 6'd0), 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fq_count !== 3'd4) begin errors++; $display("FAIL simul4_count_pre got %0d exp 4", fq_count); end
    checks++; if (fq_allowin !== 1'b0) begin errors++; $display("FAIL simul4_allowin got %0b exp 0", fq_allowin); end
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fq_count !== 3'd3) begin errors++; $display("FAIL simul4_count_post got %0d exp 3", fq_count); end
    checks++; if (fq_to_id_bus[79:48] !== 32'h28) begin errors++; $display("FAIL simul4_head_post got %h exp 28", fq_to_id_bus[79:48]); end
    tick();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (fq_to_id_bus !== e_head) begin errors++; $display("FAIL simul_drain got %h exp %h", fq_to_id_bus, e_head); end
      tick();
    end
  endtask

  task automatic test_flush();
    set_in(1'b1, mk(32'h40, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h44, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h48, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h4c, 1'b0, 6'd0), 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (fq_to_id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", fq_to_id_valid); end
    checks++; if (fq_allowin !== 1'b0) begin errors++; $display("FAIL flush_allowin got %0b exp 0", fq_allowin); end
    tick();
    set_in(1'b1, mk(32'h1c00_8000, 1'b0, 6'd0), 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", fq_count); end
    checks++; if (fq_to_id_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid got %0b exp 0", fq_to_id_valid); end
    checks++; if (fq_allowin !== 1'b1) begin errors++; $display("FAIL flush_reaccept got %0b exp 1", fq_allowin); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fq_to_id_valid !== 1'b1 || fq_to_id_bus[79:48] !== 32'h1c00_8000) begin errors++; $display("FAIL flush_first_pc got %0b/%h exp 1/1c008000", fq_to_id_valid, fq_to_id_bus[79:48]); end
    tick();
  endtask

  task automatic test_exception();
    set_in(1'b1, mk(32'h10, 1'b1, 6'h08), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h14, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fq_excep_hold !== 1'b1) begin errors++; $display("FAIL excep_hold got %0b exp 1", fq_excep_hold); end
    checks++; if (fq_allowin !== 1'b0) begin errors++; $display("FAIL excep_allowin got %0b exp 0", fq_allowin); end
    tick();
    set_in(1'b1, mk(32'h14, 1'b0, 6'd0), 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fq_to_id_valid !== 1'b1 || fq_to_id_bus[79:48] !== 32'h10) begin errors++; $display("FAIL excep_head got %0b/%h exp 1/10", fq_to_id_valid, fq_to_id_bus[79:48]); end
    checks++; if (fq_to_id_bus[47:41] !== 7'h48) begin errors++; $display("FAIL excep_ecode got %h exp 48", fq_to_id_bus[47:41]); end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, mk(32'h14, 1'b0, 6'd0), 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (fq_to_id_valid !== 1'b0 || fq_count !== 3'd0 || fq_allowin !== 1'b0) begin errors++; $display("FAIL excep_blocked got v=%0b c=%0d a=%0b exp 0/0/0", fq_to_id_valid, fq_count, fq_allowin); end
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    set_in(1'b1, mk(32'h18, 1'b0, 6'd0), 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fq_excep_hold !== 1'b0 || fq_allowin !== 1'b1) begin errors++; $display("FAIL excep_clear got h=%0b a=%0b exp 0/1", fq_excep_hold, fq_allowin); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fq_to_id_bus[79:48] !== 32'h18) begin errors++; $display("FAIL excep_resume_pc got %h exp 18", fq_to_id_bus[79:48]); end
    tick();
  endtask

  task automatic test_async_reset();
    set_in(1'b1, mk(32'h60, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h64, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32'h68, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fq_count !== 3'd3) begin errors++; $display("FAIL areset_pre_count got %0d exp 3", fq_count); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (fq_to_id_valid !== 1'b0 || fq_count !== 3'd0) begin errors++; $display("FAIL areset_drop got v=%0b c=%0d exp 0/0", fq_to_id_valid, fq_count); end
    checks++; if (fq_allowin !== 1'b0) begin errors++; $display("FAIL areset_allowin got %0b exp 0", fq_allowin); end
    exp_q.delete();
    m_hold = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    set_in(1'b1, mk(32'h70, 1'b0, 6'd0), 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fq_count !== 3'd1 || fq_to_id_bus[79:48] !== 32'h70) begin errors++; $display("FAIL areset_first got c=%0d pc=%h exp 1/70", fq_count, fq_to_id_bus[79:48]); end
    checks++; if (dut.entry[0] !== e_head) begin errors++; $display("FAIL areset_entry0 got %h exp %h", dut.entry[0], e_head); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 3) != 0,
             mk(32'($urandom) & 32'hffff_fffc, $urandom_range(0, 9) == 0, 6'($urandom_range(0, 63))),
             $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      #1;
      checks++; if (fq_allowin !== e_allowin) begin errors++; $display("FAIL rand_allowin n=%0d got %0b exp %0b", n, fq_allowin, e_allowin); end
      checks++; if (fq_to_id_valid !== e_valid) begin errors++; $display("FAIL rand_valid n=%0d got %0b exp %0b", n, fq_to_id_valid, e_valid); end
      checks++; if (fq_count !== 3'(e_count)) begin errors++; $display("FAIL rand_count n=%0d got %0d exp %0d", n, fq_count, e_count); end
      checks++; if (fq_excep_hold !== e_hold) begin errors++; $display("FAIL rand_hold n=%0d got %0b exp %0b", n, fq_excep_hold, e_hold); end
      if (e_valid) begin
        checks++; if (fq_to_id_bus !== e_head) begin errors++; $display("FAIL rand_bus n=%0d got %h exp %h", n, fq_to_id_bus, e_head); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill_full();
    test_simul();
    test_flush();
    test_exception();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Decoupling instruction queue between the IF stage and the ID stage.
- Accepts the 112-bit fetch bundle {inst, pc, excep_en, ecode, esubcode, badv} from IF and holds up to DEPTH entries in order.
- Presents the oldest entry to ID, so IF can keep fetching while ID stalls on hazards.
- A flush from WB (exception, ertn, refetch) or a branch redirect from ID empties the queue.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width, log2(DEPTH).
- BUS_W, 112, fetch bundle width. Layout from MSB: inst[111:80], pc[79:48], excep_en[47], ecode[46:41], esubcode[40:32], badv[31:0].

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- if_to_fq_valid  input  1  IF holds a valid bundle.
- if_to_fq_bus  input  112  fetch bundle.
- fq_allowin  output  1  queue accepts a bundle this cycle; drives IF's downstream allowin.
- fq_to_id_valid  output  1  oldest entry valid.
- fq_to_id_bus  output  112  oldest entry.
- id_allowin  input  1  ID consumes the head this cycle.
- flush  input  1  WB flush, one-cycle pulse.
- br_taken  input  1  ID redirect, one-cycle pulse.
- fq_count  output  PTR_W+1  current occupancy.
- fq_excep_hold  output  1  an exception bundle has been enqueued; further enqueue is blocked.

Behaviour:
- Reset (asynchronous, resetn=0): wr_ptr=0, rd_ptr=0, count=0, excep_hold=0, all entry valid bits=0. Resulting outputs: fq_to_id_valid=0, fq_allowin=0 while in reset, fq_count=0, fq_excep_hold=0, fq_to_id_bus=0. Reset mid-operation discards all entries immediately.
- kill = flush | br_taken.
- fq_allowin = resetn & ~kill & ~excep_hold & (count != DEPTH). Purely a function of registered state plus kill; no dependency on id_allowin. A full queue does not accept, even if ID dequeues in the same cycle.
- enq = if_to_fq_valid & fq_allowin. On enq: entry[wr_ptr] <= bus; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- fq_to_id_valid = (count != 0) & ~kill.
- fq_to_id_bus = entry[rd_ptr], unregistered read.
- deq = fq_to_id_valid & id_allowin. On deq: rd_ptr <= rd_ptr+1, wrapping.
- count update:
  - +1 on enq only.
  - -1 on deq only.
  - unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Latency: a bundle enqueued at edge N is visible at fq_to_id_bus after edge N. There is no combinational bypass; minimum IF->ID latency is one cycle through the queue.
- excep_hold:
  - Set on enq when if_to_fq_bus[47]=1.
  - Cleared on kill; kill has priority over set in the same cycle.
  - While set, no enqueue occurs, but dequeue continues. The exception entry still reaches ID, and later bundles are never admitted behind it.
- kill cycle:
  - enq and deq are suppressed.
  - At the next edge: wr_ptr=rd_ptr=0, count=0, excep_hold=0.
  - The queue accepts again in the following cycle.
  - kill takes priority over a simultaneous if_to_fq_valid or id_allowin.
- Wrap-around: pointers wrap silently. Full/empty is decided by count, never by pointer equality.
- Data outputs are don't-care when fq_to_id_valid=0. The bench checks them only when valid.

Test Plan:
- Streaming: ID always ready; 8 bundles with pc=0x1c000000+4k, one per cycle -> queue delivers them in order, each one cycle after its enqueue. fq_count stays at 1 in steady state; fq_allowin stays 1.
- Fill/full: id_allowin=0; drive 5 bundles (pc 0x00,0x04,0x08,0x0c,0x10).
  - After 4 enqueues: fq_count=4, fq_allowin=0; the fifth bundle is held by IF.
  - Raise id_allowin -> order is 0x00,0x04,0x08,0x0c, then 0x10 enters.
  - Pointers wrap with no loss.
- Simultaneous enq/deq at count=2 -> count stays 2 and head advances correctly. Same at count=4 -> only the dequeue occurs, count=3.
- Flush with 3 entries plus IF valid: pulse flush -> fq_to_id_valid=0 in the flush cycle; fq_count=0 next cycle; no flushed pc ever reaches ID. The next bundle (pc=0x1c008000) is the first delivered.
- Exception stop: enqueue pc=0x10 with excep_en=1, ecode=0x08, then IF offers pc=0x14.
  - Expect fq_excep_hold=1 and fq_allowin=0.
  - pc=0x10 is delivered with ecode 0x08; pc=0x14 is never enqueued.
  - flush then clears hold.
- Async reset mid-stream at count=3 with resetn deasserted between edges -> outputs drop immediately: fq_to_id_valid=0, fq_count=0. After release, the first enqueue lands in entry 0.
